// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and the address-check helper for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dm_state_t;
  localparam int WORD_BYTES = 4;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;
  function automatic logic isBadAddr(input logic [31:0] addr, input logic [31:0] base, input int unsigned depth);
    logic [31:0] offset;
    offset = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || ((offset >> $clog2(WORD_BYTES)) >= depth);
  endfunction
endpackage

// File: rtl/dmem_word_ram.sv
// dmem_word_ram: DEPTH_WORDS x 32 RAM with synchronous write and registered read, no reset
module dmem_word_ram #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: one-at-a-time load/store target with programmable wait states
// and misaligned/out-of-range detection in front of a word RAM.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  dm_state_t state, nextState;
  dm_req_t held, cur;
  logic [3:0] waitCnt;
  logic accept, enterResp, badAddr, ramWe, ramRe, loadOk;
  logic [IW-1:0] wordIdx;
  logic [31:0] ramQ;
  always_comb begin
    nextState = state;
    req_ready = 1'b0;
    unique case (state)
      DM_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nextState = (WAIT_CYCLES == 0) ? DM_RESP : DM_WAIT;
      end
      DM_WAIT: if (waitCnt == 4'd0) nextState = DM_RESP;
      default: nextState = DM_IDLE;
    endcase
  end
  // With zero wait states the RAM access happens on the accepting edge, so use the live request in IDLE.
  assign cur       = (state == DM_IDLE) ? dm_req_t'({req_write, req_addr, req_wdata}) : held;
  assign accept    = req_valid && req_ready;
  assign badAddr   = isBadAddr(cur.addr, BASE_ADDR, DEPTH_WORDS);
  assign wordIdx   = IW'((cur.addr - BASE_ADDR) >> $clog2(WORD_BYTES));
  assign enterResp = reset && (nextState == DM_RESP);
  assign ramWe     = enterResp && cur.write && !badAddr;
  assign ramRe     = enterResp && !cur.write && !badAddr;
  assign rsp_rdata = loadOk ? ramQ : 32'h0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DM_IDLE;
      held      <= '0;
      waitCnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      loadOk    <= 1'b0;
    end else begin
      state     <= nextState;
      rsp_valid <= enterResp;
      rsp_err   <= enterResp && badAddr;
      loadOk    <= ramRe;
      if (accept) begin
        held    <= cur;
        waitCnt <= CNT_LOAD;
      end else if (state == DM_WAIT && waitCnt != 4'd0) begin
        waitCnt <= waitCnt - 4'd1;
      end
    end
  end
  dmem_word_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (ramWe),
    .re    (ramRe),
    .idx   (wordIdx),
    .wdata (cur.wdata),
    .rdata (ramQ)
  );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: scoreboard bench over three responders with 0, 1 and 3 wait states
module tb_data_memory_responder;
  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  typedef struct {
    int          lat;
    int          low;
    logic [31:0] rd;
    logic        er;
    logic        aRdy;
    logic        aVal;
    logic [31:0] aRd;
    logic        aErr;
  } obs_t;
  logic clk = 0, reset = 0, reqValid = 0, reqWrite = 0;
  logic [31:0] reqAddr = 0, reqWdata = 0;
  int sel = 0;
  logic [2:0] ready, rspValid, rspErr;
  logic [31:0] rspRdata [3];
  logic [31:0] model [3][64];
  exp_t sbq[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder #(
      .DEPTH_WORDS (64),
      .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 1 : 3)),
      .BASE_ADDR   (32'h0)
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (reqValid && sel == g),
      .req_write (reqWrite),
      .req_addr  (reqAddr),
      .req_wdata (reqWdata),
      .req_ready (ready[g]),
      .rsp_valid (rspValid[g]),
      .rsp_rdata (rspRdata[g]),
      .rsp_err   (rspErr[g])
    );
  end
  task automatic sendReq(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input bit push, input bit hold);
    exp_t e;
    logic bad;
    bad = (a[1:0] != 2'b00) || (a >= 32'h100);
    e.lat = (i == 0) ? 1 : (i == 1) ? 2 : 4;
    e.err = bad;
    e.rdata = (w || bad) ? 32'h0 : model[i][a[7:2]];
    if (push) begin
      sbq.push_back(e);
      if (w && !bad) model[i][a[7:2]] = d;
    end
    @(negedge clk);
    sel = i; reqValid = 1; reqWrite = w; reqAddr = a; reqWdata = d;
    @(posedge clk); #1;
    if (!hold) reqValid = 0;
  endtask
  task automatic waitRsp(input int i, output obs_t o);
    o = '{default: 0};
    o.lat = 1;
    while (rspValid[i] !== 1'b1 && o.lat < 20) begin
      if (ready[i] === 1'b0) o.low++;
      @(posedge clk); #1;
      o.lat++;
    end
    if (ready[i] === 1'b0) o.low++;
    o.rd = rspRdata[i];
    o.er = rspErr[i];
  endtask
  task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, output obs_t o, output exp_t e);
    sendReq(i, w, a, d, 1, 0);
    waitRsp(i, o);
    e = sbq.pop_front();
    @(posedge clk); #1;
    o.aRdy = ready[i]; o.aVal = rspValid[i]; o.aRd = rspRdata[i]; o.aErr = rspErr[i];
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ready[i], rspValid[i], rspErr[i]} !== 3'b100 || rspRdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset[%0d] got rdy=%b vld=%b err=%b rd=%h want rdy=1 vld=0 err=0 rd=0", i, ready[i], rspValid[i], rspErr[i], rspRdata[i]);
      end
    end
  endtask
  task automatic test_store_load();
    obs_t o;
    exp_t e;
    logic        w [2] = '{1'b1, 1'b0};
    logic [31:0] d [2] = '{32'hDEADBEEF, 32'h0};
    for (int k = 0; k < 2; k++) begin
      xfer(1, w[k], 32'h10, d[k], o, e);
      checks++;
      if (o.lat !== 2 || o.low !== 2) begin
        errors++; $display("FAIL st_ld[%0d] lat/low got %0d/%0d want 2/2", k, o.lat, o.low);
      end
      checks++;
      if (o.rd !== (w[k] ? 32'h0 : 32'hDEADBEEF) || o.er !== 1'b0) begin
        errors++; $display("FAIL st_ld[%0d] rdata/err got %h/%b want %h/0", k, o.rd, o.er, e.rdata);
      end
      checks++;
      if ({o.aRdy, o.aVal, o.aErr} !== 3'b100 || o.aRd !== 32'h0) begin
        errors++; $display("FAIL st_ld[%0d] after got rdy=%b vld=%b err=%b rd=%h want 1/0/0/0", k, o.aRdy, o.aVal, o.aErr, o.aRd);
      end
    end
  endtask
  task automatic test_latency();
    obs_t o;
    exp_t e;
    int i;
    for (int k = 0; k < 2; k++) begin
      i = 2 * k;
      xfer(i, 1'b1, 32'h0, 32'h11110000 | k, o, e);
      xfer(i, 1'b0, 32'h0, 32'h0, o, e);
      checks++;
      if (o.lat !== (k == 0 ? 1 : 4)) begin
        errors++; $display("FAIL latency[wait%0d] got %0d want %0d", i == 0 ? 0 : 3, o.lat, e.lat);
      end
      checks++;
      if (o.rd !== (32'h11110000 | k) || o.er !== 1'b0) begin
        errors++; $display("FAIL latency_data[%0d] got %h/%b want %h/0", i, o.rd, o.er, e.rdata);
      end
      checks++;
      if (o.aVal !== 1'b0 || o.aRd !== 32'h0 || o.aRdy !== 1'b1) begin
        errors++; $display("FAIL latency_pulse[%0d] after got vld=%b rd=%h rdy=%b want 0/0/1", i, o.aVal, o.aRd, o.aRdy);
      end
    end
  endtask
  task automatic test_errors();
    obs_t o;
    exp_t e;
    logic        w [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    logic [31:0] a [10] = '{32'h13, 32'hFC, 32'h0, 32'h100, 32'h12, 32'hFC, 32'h0, 32'h10, 32'h200, 32'hFFFFFFFC};
    logic [31:0] d [10] = '{0, 32'hCAFEF00D, 32'h13572468, 32'h1234, 32'hBAD0BAD0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 10; k++) begin
      xfer(1, w[k], a[k], d[k], o, e);
      checks++;
      if (o.er !== e.err || o.rd !== e.rdata || o.lat !== e.lat) begin
        errors++; $display("FAIL err[%0d] addr=%h got err=%b rd=%h lat=%0d want err=%b rd=%h lat=%0d", k, a[k], o.er, o.rd, o.lat, e.err, e.rdata, e.lat);
      end
      checks++;
      if (o.aErr !== 1'b0 || o.aRd !== 32'h0) begin
        errors++; $display("FAIL err_clear[%0d] got err=%b rd=%h want 0/0", k, o.aErr, o.aRd);
      end
    end
  endtask
  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    int seen;
    xfer(2, 1'b1, 32'h20, 32'h5A5A5A5A, o, e);
    sendReq(2, 1'b1, 32'h20, 32'hAA, 0, 0);
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rspValid[2] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_mid pulses got %0d want 0", seen);
    end
    checks++;
    if (ready[2] !== 1'b1) begin
      errors++; $display("FAIL reset_mid ready got %b want 1", ready[2]);
    end
    xfer(2, 1'b0, 32'h20, 32'h0, o, e);
    checks++;
    if (o.rd !== 32'h5A5A5A5A || o.er !== 1'b0 || o.lat !== 4) begin
      errors++; $display("FAIL reset_mid load got rd=%h err=%b lat=%0d want 5a5a5a5a/0/4", o.rd, o.er, o.lat);
    end
  endtask
  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    xfer(1, 1'b1, 32'h30, 32'h30303030, o, e);
    xfer(1, 1'b1, 32'h34, 32'h34343434, o, e);
    sendReq(1, 1'b0, 32'h30, 32'h0, 1, 1);
    reqAddr = 32'h34;
    waitRsp(1, o);
    e = sbq.pop_front();
    checks++;
    if (o.rd !== 32'h30303030 || o.lat !== e.lat) begin
      errors++; $display("FAIL holdoff_first got rd=%h lat=%0d want 30303030/%0d", o.rd, o.lat, e.lat);
    end
    @(posedge clk); #1;
    checks++;
    if (ready[1] !== 1'b1 || rspValid[1] !== 1'b0) begin
      errors++; $display("FAIL holdoff_idle got rdy=%b vld=%b want 1/0", ready[1], rspValid[1]);
    end
    sbq.push_back('{2, 32'h34343434, 1'b0});
    @(posedge clk); #1;
    reqValid = 0;
    checks++;
    if (ready[1] !== 1'b0) begin
      errors++; $display("FAIL holdoff_accept ready got %b want 0", ready[1]);
    end
    waitRsp(1, o);
    e = sbq.pop_front();
    checks++;
    if (o.rd !== e.rdata || o.lat !== e.lat || o.er !== e.err) begin
      errors++; $display("FAIL holdoff_second got rd=%h lat=%0d err=%b want %h/%0d/%b", o.rd, o.lat, o.er, e.rdata, e.lat, e.err);
    end
    @(posedge clk); #1;
    checks++;
    if (sbq.size() !== 0) begin
      errors++; $display("FAIL scoreboard_left got %0d want 0", sbq.size());
    end
  endtask
  initial begin
    test_reset();
    test_store_load();
    test_latency();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
